// File: rtl/rr_reg_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_reg_arbiter_if
// Bundle of request/grant and write-data signals between N requesters and the
// shared-register arbiter.
//
//   req    N     request per requester, held high while ownership is wanted
//   wen    N     write enable per requester (only the owner's is honoured)
//   wdata  N*DW  write data, slice i = wdata[i*DW +: DW]
//   gnt    N     one-hot registered grant, zero when idle
//   q      DW    shared register contents
//   busy   1     high while any grant bit is set
//
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_reg_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  logic [N-1:0]    req;
  logic [N-1:0]    wen;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   q;
  logic            busy;

  modport master (output req, wen, wdata, input gnt, q, busy);
  modport slave  (input req, wen, wdata, output gnt, q, busy);
endinterface

// File: rtl/rr_reg_arbiter.sv
// ---------------------------------------------------------------------------
// rr_reg_arbiter
// Round-robin arbiter sharing one DW-bit register between N requesters.
// The current owner may write the register; ownership rotates on release.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-low
//   bus  rr_reg_arbiter_if.slave (req, wen, wdata in; gnt, q, busy out)
//
// Parameters: N (2..8) requesters, DW register width, MAX_HOLD (>=2) grant
// limit in cycles.
//
// Optional feature: define ARB_TIMEOUT_EN to force a release after MAX_HOLD
// consecutive grant cycles when another requester is waiting. Without it the
// owner keeps the grant for as long as it holds req.
// ---------------------------------------------------------------------------
module rr_reg_arbiter #(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  rr_reg_arbiter_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  // Elaboration-time parameter sanity checks.
  if (N < 2 || N > 8) begin : g_bad_n
    $error("rr_reg_arbiter: N must be in 2..8");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("rr_reg_arbiter: MAX_HOLD must be >= 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   ptr_q, ptr_d;     // last owner; search starts just after it
  logic [N-1:0]    gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   q_q, q_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD) + 1;
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  // Round-robin search: first set bit of mask at base+1, base+2, ... mod N.
  // Returns {found, index}. Iterating from the far end lets the nearest
  // candidate overwrite the others, so no separate found flag is needed.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] mask,
                                          input logic [PW-1:0] base);
    logic [PW:0]   r;
    logic [PW-1:0] idx;
    r = '0;
    for (int k = N; k >= 1; k--) begin
      idx = PW'((int'(base) + k) % N);
      if (mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  logic [PW:0]   idle_pick;
  logic [PW:0]   other_pick;
  logic [N-1:0]  owner_oh;
  logic [DW-1:0] owner_wdata;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    q_d         = q_q;
    owner_wdata = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    owner_oh = N'(1) << owner_q;
    for (int i = 0; i < N; i++) begin
      if (owner_q == PW'(i)) owner_wdata = bus.wdata[i*DW +: DW];
    end
    idle_pick  = rr_pick(bus.req, ptr_q);
    // Excluding the owner matters for forced release, where req[owner] is high.
    other_pick = rr_pick(bus.req & ~owner_oh, owner_q);

    case (state_q)
      IDLE: begin
        if (idle_pick[PW]) begin
          state_d = GRANT;
          owner_d = idle_pick[PW-1:0];
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      GRANT: begin
        if (bus.req[owner_q]) begin
          if (bus.wen[owner_q]) q_d = owner_wdata;
`ifdef ARB_TIMEOUT_EN
          if (cnt_q == CW'(MAX_HOLD - 1)) begin
            // Limit reached: hand over only if someone is waiting; otherwise
            // the counter saturates and the owner keeps the grant.
            if (other_pick[PW]) begin
              owner_d = other_pick[PW-1:0];
              ptr_d   = owner_q;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end else begin
          // Voluntary release: the write on this edge is ignored.
          ptr_d = owner_q;
          if (other_pick[PW]) begin
            owner_d = other_pick[PW-1:0];
`ifdef ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    gnt_d  = (state_d == GRANT) ? (N'(1) << owner_d) : '0;
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= PW'(N - 1);
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      q_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      q_q     <= q_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.q    = q_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_reg_arbiter
// Directed self-checking bench for rr_reg_arbiter (N=4, DW=8, MAX_HOLD=8).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_rr_reg_arbiter;

  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  rr_reg_arbiter_if #(.N(N), .DW(DW)) bus ();

  rr_reg_arbiter #(.N(N), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [3:0] oh;

  initial begin
    bus.req   = '0;
    bus.wen   = '0;
    bus.wdata = '0;

    // 1) Reset state.
    do_reset();
    tick();
    check("reset_gnt",  bus.gnt,  4'b0000);
    check("reset_q",    bus.q,    8'h00);
    check("reset_busy", bus.busy, 1'b0);

    // 2) Basic grant, back-to-back handover, return to idle.
    bus.req = 4'b0101;
    tick();
    check("first_grant", bus.gnt, 4'b0001);
    check("first_busy",  bus.busy, 1'b1);
    bus.req = 4'b0100;
    tick();
    check("handover_2", bus.gnt, 4'b0100);
    bus.req = 4'b0000;
    tick();
    check("idle_gnt",  bus.gnt,  4'b0000);
    check("idle_busy", bus.busy, 1'b0);

    // 3) Owner-only writes.
    bus.req = 4'b0010;
    tick();
    check("owner1_gnt", bus.gnt, 4'b0010);
    bus.wen   = 4'b0011;
    bus.wdata = {8'h00, 8'h00, 8'hA5, 8'h3C};
    tick();
    check("owner_write", bus.q, 8'hA5);
    bus.wen   = 4'b0000;
    bus.wdata = {8'h00, 8'h00, 8'h11, 8'h22};
    tick();
    check("wen0_hold", bus.q, 8'hA5);
    bus.wen   = 4'b1101;
    bus.wdata = {8'h44, 8'h33, 8'h99, 8'h77};
    tick();
    check("nonowner_wen", bus.q, 8'hA5);
    // Release edge: owner's wen must be ignored.
    bus.req   = 4'b0000;
    bus.wen   = 4'b0010;
    bus.wdata = {8'h00, 8'h00, 8'h5A, 8'h00};
    tick();
    check("release_wen_gnt", bus.gnt, 4'b0000);
    check("release_wen_q",   bus.q,   8'hA5);
    bus.wen   = 4'b1111;
    bus.wdata = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    tick();
    check("idle_wen_q", bus.q, 8'hA5);
    bus.wen = 4'b0000;

    // 4) Full rotation with all requesting; each owner holds 2 cycles.
    do_reset();
    check("rot_reset_q", bus.q, 8'h00);
    bus.req = 4'b1111;
    tick();
    for (int s = 0; s < 5; s++) begin
      oh = 4'b0001 << (s % 4);
      check($sformatf("rot%0d_c1", s), bus.gnt, oh);
      check($sformatf("rot%0d_busy", s), bus.busy, 1'b1);
      bus.req = 4'b1111;
      tick();
      check($sformatf("rot%0d_c2", s), bus.gnt, oh);
      bus.req = 4'b1111 & ~oh;
      tick();
    end
    // After releasing 0 on the 5th turn, owner 1 takes over.
    check("rot_after", bus.gnt, 4'b0010);

    // 6) Reset while owner 2 is writing.
    bus.req = 4'b0100;
    tick();
    check("owner2_gnt", bus.gnt, 4'b0100);
    bus.wen   = 4'b0100;
    bus.wdata = {8'h00, 8'hFF, 8'h00, 8'h00};
    tick();
    check("owner2_write", bus.q, 8'hFF);
    rst = 1'b0;
    tick();
    check("midrst_gnt",  bus.gnt,  4'b0000);
    check("midrst_q",    bus.q,    8'h00);
    check("midrst_busy", bus.busy, 1'b0);
    rst     = 1'b1;
    bus.wen = 4'b0000;
    bus.req = 4'b1100;
    tick();
    check("ptr_reset", bus.gnt, 4'b0100);

    // 5) Hold behaviour with two requesters held high.
    do_reset();
    bus.req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < MAX_HOLD; c++) begin
      tick();
      check($sformatf("to_own0_%0d", c), bus.gnt, 4'b0001);
    end
    for (int c = 0; c < MAX_HOLD; c++) begin
      tick();
      check($sformatf("to_own1_%0d", c), bus.gnt, 4'b0010);
    end
    tick();
    check("to_back0", bus.gnt, 4'b0001);
    // Sole requester keeps the grant indefinitely.
    bus.req = 4'b0001;
    for (int c = 0; c < 22; c++) begin
      tick();
      check($sformatf("to_sole_%0d", c), bus.gnt, 4'b0001);
    end
`else
    for (int c = 0; c < 3 * MAX_HOLD; c++) begin
      tick();
      check($sformatf("hold0_%0d", c), bus.gnt, 4'b0001);
    end
    bus.req = 4'b0010;
    tick();
    check("hold_release", bus.gnt, 4'b0010);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
